// File: rtl/move_check_sequencer_if.sv
// Bundle of request, board, checker and response signals between the game-play
// FSM / per-piece checkers (master side) and the move check sequencer (slave side).
interface move_check_sequencer_if;
  // Both req and resp use valid/ready: a transfer happens on a rising clk edge
  // where valid && ready; valid, once raised, holds its payload until that edge.
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            old_x;
  logic [2:0]            old_y;
  logic [2:0]            new_x;
  logic [2:0]            new_y;
  logic                  side_to_move;
  logic [7:0][7:0][3:0]  board_in;
  logic [2:0]            h_delta;
  logic [2:0]            v_delta;
  logic [3:0]            piece_type;
  logic [5:0]            chk_start;
  logic [5:0]            chk_done;
  logic [5:0]            chk_result;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_legal;
  logic [2:0]            resp_code;

  modport master (
    output req_valid, old_x, old_y, new_x, new_y, side_to_move, board_in,
           chk_done, chk_result, resp_ready,
    input  req_ready, h_delta, v_delta, piece_type, chk_start,
           resp_valid, resp_legal, resp_code
  );

  modport slave (
    input  req_valid, old_x, old_y, new_x, new_y, side_to_move, board_in,
           chk_done, chk_result, resp_ready,
    output req_ready, h_delta, v_delta, piece_type, chk_start,
           resp_valid, resp_legal, resp_code
  );
endinterface

// File: rtl/move_check_sequencer.sv
// Accepts one move, runs piece-independent pre-checks, dispatches exactly one
// per-piece checker, waits for it under a watchdog and returns a coded verdict.
module move_check_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  move_check_sequencer_if.slave   bus,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRECHECK = 3'd1,
    S_DISPATCH = 3'd2,
    S_WAIT     = 3'd3,
    S_RESPOND  = 3'd4
  } state_t;

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] old_x_q, old_x_d, old_y_q, old_y_d;
  logic [2:0] new_x_q, new_x_d, new_y_q, new_y_d;
  logic       side_q, side_d;
  logic [2:0] h_delta_q, h_delta_d, v_delta_q, v_delta_d;
  logic [3:0] piece_type_q, piece_type_d;
  logic [7:0] wd_q, wd_d;
  logic       resp_legal_q, resp_legal_d;
  logic [2:0] resp_code_q, resp_code_d;

  logic [3:0] src, dst;
  logic [2:0] h_abs, v_abs, fault_code;
  logic [2:0] sel;
  logic [5:0] sel_onehot;
  logic       sel_done, sel_result;

  // Pre-check decode from the latched coordinates and the live board.
  always_comb begin
    src   = bus.board_in[old_x_q][old_y_q];
    dst   = bus.board_in[new_x_q][new_y_q];
    h_abs = (new_x_q >= old_x_q) ? (new_x_q - old_x_q) : (old_x_q - new_x_q);
    v_abs = (new_y_q >= old_y_q) ? (new_y_q - old_y_q) : (old_y_q - new_y_q);
    if (src[2:0] == 3'd0)                            fault_code = 3'd1;
    else if (src[2:0] == 3'd7)                       fault_code = 3'd7;
    else if (src[3] != side_q)                       fault_code = 3'd2;
    else if (h_abs == 3'd0 && v_abs == 3'd0)         fault_code = 3'd3;
    else if (dst[2:0] != 3'd0 && dst[3] == src[3])   fault_code = 3'd4;
    else                                             fault_code = 3'd0;
  end

  // Only the checker matching the registered piece type is ever observed.
  always_comb begin
    sel        = piece_type_q[2:0] - 3'd1;
    sel_onehot = 6'd1 << sel;
    sel_done   = |(bus.chk_done & sel_onehot);
    sel_result = |(bus.chk_result & sel_onehot);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      old_x_q      <= 3'd0;
      old_y_q      <= 3'd0;
      new_x_q      <= 3'd0;
      new_y_q      <= 3'd0;
      side_q       <= 1'b0;
      h_delta_q    <= 3'd0;
      v_delta_q    <= 3'd0;
      piece_type_q <= 4'd0;
      wd_q         <= 8'd0;
      resp_legal_q <= 1'b0;
      resp_code_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      side_q       <= side_d;
      h_delta_q    <= h_delta_d;
      v_delta_q    <= v_delta_d;
      piece_type_q <= piece_type_d;
      wd_q         <= wd_d;
      resp_legal_q <= resp_legal_d;
      resp_code_q  <= resp_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    side_d       = side_q;
    h_delta_d    = h_delta_q;
    v_delta_d    = v_delta_q;
    piece_type_d = piece_type_q;
    wd_d         = wd_q;
    resp_legal_d = resp_legal_q;
    resp_code_d  = resp_code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          old_x_d = bus.old_x;
          old_y_d = bus.old_y;
          new_x_d = bus.new_x;
          new_y_d = bus.new_y;
          side_d  = bus.side_to_move;
          state_d = S_PRECHECK;
        end
      end
      S_PRECHECK: begin
        piece_type_d = src;
        h_delta_d    = h_abs;
        v_delta_d    = v_abs;
        resp_legal_d = 1'b0;
        resp_code_d  = fault_code;
        state_d      = (fault_code != 3'd0) ? S_RESPOND : S_DISPATCH;
      end
      S_DISPATCH: begin
        wd_d    = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the watchdog's last cycle still wins.
        if (sel_done) begin
          resp_legal_d = sel_result;
          resp_code_d  = sel_result ? 3'd0 : 3'd5;
          state_d      = S_RESPOND;
        end else if (wd_q == WD_LIMIT) begin
          resp_legal_d = 1'b0;
          resp_code_d  = 3'd6;
          state_d      = S_RESPOND;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      S_RESPOND: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are gated by reset so nothing escapes during an abort.
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE) && !reset;
    bus.chk_start  = (state_q == S_DISPATCH && !reset) ? sel_onehot : 6'd0;
    bus.resp_valid = (state_q == S_RESPOND) && !reset;
    bus.resp_legal = resp_legal_q;
    bus.resp_code  = resp_code_q;
    bus.h_delta    = h_delta_q;
    bus.v_delta    = v_delta_q;
    bus.piece_type = piece_type_q;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_move_check_sequencer.sv
// Bench for move_check_sequencer: directed vector table, reset corner cases,
// and randomized moves scored against a rule-level reference model.
module tb_move_check_sequencer;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  move_check_sequencer_if bus();

  move_check_sequencer #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [3:0] src; logic [3:0] dst;
    logic [2:0] ox; logic [2:0] oy; logic [2:0] nx; logic [2:0] ny;
    logic side; int dd; logic res; int stall;
    logic [2:0] code; logic legal; int lat; logic [5:0] start;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0][7:0][3:0] b,
                                input logic [2:0] ox, input logic [2:0] oy,
                                input logic [2:0] nx, input logic [2:0] ny,
                                input logic side, input int dd, input logic res,
                                output logic [2:0] code, output logic legal,
                                output int lat, output logic [5:0] start);
    logic [3:0] s, d;
    s = b[ox][oy];
    d = b[nx][ny];
    start = 6'd0; legal = 1'b0; lat = 2; code = 3'd0;
    if (s[2:0] == 3'd0) code = 3'd1;
    else if (s[2:0] == 3'd7) code = 3'd7;
    else if (s[3] != side) code = 3'd2;
    else if (ox == nx && oy == ny) code = 3'd3;
    else if (d[2:0] != 3'd0 && d[3] == s[3]) code = 3'd4;
    else begin
      start = 6'd1 << (int'(s[2:0]) - 1);
      if (dd < TO) begin
        lat = 4 + dd; legal = res; code = res ? 3'd0 : 3'd5;
      end else begin
        lat = 3 + TO; code = 3'd6;
      end
    end
  endfunction

  task automatic clear_board();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        bus.board_in[x][y] = 4'd0;
  endtask

  task automatic random_board();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        bus.board_in[x][y] = ($urandom_range(0, 3) < 2) ? 4'd0 : 4'($urandom_range(0, 15));
  endtask

  // Returns at the falling edge of the cycle after the accept (offset 1).
  task automatic launch(input logic [2:0] ox, input logic [2:0] oy,
                        input logic [2:0] nx, input logic [2:0] ny, input logic side);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.old_x = ox; bus.old_y = oy; bus.new_x = nx; bus.new_y = ny;
    bus.side_to_move = side;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.old_x = 3'($urandom); bus.old_y = 3'($urandom);
    bus.new_x = 3'($urandom); bus.new_y = 3'($urandom);
    bus.side_to_move = 1'($urandom);
  endtask

  task automatic run_txn(input string tag,
                         input logic [2:0] ox, input logic [2:0] oy,
                         input logic [2:0] nx, input logic [2:0] ny, input logic side,
                         input int dd, input logic res, input int stall,
                         input logic [2:0] exp_code, input logic exp_legal,
                         input int exp_lat, input logic [5:0] exp_start);
    logic [3:0]  src_pc;
    logic [2:0]  hd, vd;
    logic [5:0]  start_val;
    logic [11:0] e;
    int start_cnt, n;
    bit got, bad_ready;
    src_pc = bus.board_in[ox][oy];
    hd = (nx > ox) ? (nx - ox) : (ox - nx);
    vd = (ny > oy) ? (ny - oy) : (oy - ny);
    exp_q.push_back({exp_legal, exp_code, 8'(exp_lat)});
    launch(ox, oy, nx, ny, side);
    start_cnt = 0; start_val = 6'd0; got = 0; bad_ready = 0;
    for (n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.chk_start != 6'd0) begin
        start_cnt++;
        start_val = bus.chk_start;
      end
      if (bus.resp_valid) begin got = 1; break; end
      if (bus.req_ready) bad_ready = 1;
      bus.chk_done   = 6'($urandom) & ~exp_start;
      bus.chk_result = 6'($urandom) & ~exp_start;
      if (exp_start != 6'd0 && n == 3 + dd) begin
        bus.chk_done   = bus.chk_done | exp_start;
        if (res) bus.chk_result = bus.chk_result | exp_start;
      end
      if (n >= 2) random_board();
    end
    bus.chk_done = 6'd0;
    bus.chk_result = 6'd0;
    e = exp_q.pop_front();
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_no_resp: got no resp_valid expected at offset %0d", tag, e[7:0]);
      return;
    end
    check({tag, "_latency"}, n, 32'(e[7:0]));
    check({tag, "_legal"}, bus.resp_legal, e[11]);
    check({tag, "_code"}, bus.resp_code, e[10:8]);
    check({tag, "_piece"}, bus.piece_type, src_pc);
    check({tag, "_deltas"}, {bus.h_delta, bus.v_delta}, {hd, vd});
    check({tag, "_start_val"}, start_val, exp_start);
    check({tag, "_start_cnt"}, start_cnt, (exp_start != 6'd0) ? 1 : 0);
    check({tag, "_busy_ready"}, bad_ready, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_hold"}, {bus.resp_valid, bus.resp_legal, bus.resp_code},
            {1'b1, e[11], e[10:8]});
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "_ready_after"}, {bus.req_ready, bus.resp_valid}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [2:0] rc; logic rl; int rlat; logic [5:0] rs;
    logic [2:0] ox, oy, nx, ny; logic side;
    int violations;

    vecs[0]  = '{4'h2, 4'h0, 3'd1, 3'd0, 3'd2, 3'd2, 1'b0, 0,  1'b1, 0, 3'd0, 1'b1, 4,  6'b000010};
    vecs[1]  = '{4'h0, 4'h0, 3'd3, 3'd3, 3'd3, 3'd4, 1'b0, 0,  1'b1, 0, 3'd1, 1'b0, 2,  6'b000000};
    vecs[2]  = '{4'hC, 4'h0, 3'd0, 3'd0, 3'd0, 3'd5, 1'b0, 0,  1'b1, 0, 3'd2, 1'b0, 2,  6'b000000};
    vecs[3]  = '{4'h1, 4'h1, 3'd4, 3'd1, 3'd4, 3'd1, 1'b0, 0,  1'b1, 0, 3'd3, 1'b0, 2,  6'b000000};
    vecs[4]  = '{4'h3, 4'h1, 3'd2, 3'd0, 3'd4, 3'd2, 1'b0, 0,  1'b1, 1, 3'd4, 1'b0, 2,  6'b000000};
    vecs[5]  = '{4'h7, 4'h0, 3'd5, 3'd5, 3'd6, 3'd6, 1'b0, 0,  1'b1, 0, 3'd7, 1'b0, 2,  6'b000000};
    vecs[6]  = '{4'hF, 4'h0, 3'd5, 3'd5, 3'd6, 3'd6, 1'b0, 0,  1'b1, 0, 3'd7, 1'b0, 2,  6'b000000};
    vecs[7]  = '{4'hE, 4'h1, 3'd4, 3'd7, 3'd4, 3'd6, 1'b1, 2,  1'b1, 1, 3'd0, 1'b1, 6,  6'b100000};
    vecs[8]  = '{4'h5, 4'h0, 3'd3, 3'd0, 3'd7, 3'd4, 1'b0, 0,  1'b0, 5, 3'd5, 1'b0, 4,  6'b010000};
    vecs[9]  = '{4'h4, 4'h0, 3'd0, 3'd0, 3'd0, 3'd7, 1'b0, 99, 1'b1, 0, 3'd6, 1'b0, 19, 6'b001000};
    vecs[10] = '{4'h3, 4'h0, 3'd2, 3'd0, 3'd5, 3'd3, 1'b0, 15, 1'b1, 0, 3'd0, 1'b1, 19, 6'b000100};
    vecs[11] = '{4'h3, 4'h0, 3'd2, 3'd0, 3'd5, 3'd3, 1'b0, 15, 1'b0, 0, 3'd5, 1'b0, 19, 6'b000100};
    vecs[12] = '{4'h1, 4'h0, 3'd4, 3'd1, 3'd4, 3'd3, 1'b0, 14, 1'b1, 0, 3'd0, 1'b1, 18, 6'b000001};
    vecs[13] = '{4'hA, 4'h9, 3'd1, 3'd7, 3'd2, 3'd5, 1'b1, 0,  1'b1, 0, 3'd4, 1'b0, 2,  6'b000000};
    vecs[14] = '{4'h0, 4'h0, 3'd6, 3'd6, 3'd6, 3'd6, 1'b1, 0,  1'b1, 0, 3'd1, 1'b0, 2,  6'b000000};
    vecs[15] = '{4'h2, 4'hC, 3'd1, 3'd0, 3'd2, 3'd2, 1'b0, 1,  1'b1, 2, 3'd0, 1'b1, 5,  6'b000010};

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    bus.old_x = 3'd0; bus.old_y = 3'd0; bus.new_x = 3'd0; bus.new_y = 3'd0;
    bus.side_to_move = 1'b0; bus.chk_done = 6'd0; bus.chk_result = 6'd0;
    clear_board();

    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst_outputs_held", {bus.req_ready, bus.resp_valid, bus.chk_start}, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_regs", {bus.resp_valid, bus.resp_legal, bus.resp_code, bus.h_delta,
                       bus.v_delta, bus.piece_type}, 18'd0);

    // Directed vectors
    foreach (vecs[i]) begin
      clear_board();
      bus.board_in[vecs[i].nx][vecs[i].ny] = vecs[i].dst;
      bus.board_in[vecs[i].ox][vecs[i].oy] = vecs[i].src;
      run_txn($sformatf("vec%0d", i), vecs[i].ox, vecs[i].oy, vecs[i].nx, vecs[i].ny,
              vecs[i].side, vecs[i].dd, vecs[i].res, vecs[i].stall,
              vecs[i].code, vecs[i].legal, vecs[i].lat, vecs[i].start);
    end

    // Reset held 3 cycles during WAIT aborts silently
    clear_board();
    bus.board_in[0][0] = 4'h4;
    launch(3'd0, 3'd0, 3'd0, 3'd3, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    violations = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid || bus.chk_start != 6'd0 || bus.req_ready) violations++;
    end
    check("wait_rst_quiet", violations, 0);
    reset = 1'b0;
    @(negedge clk);
    check("wait_rst_ready", bus.req_ready, 1'b1);
    check("wait_rst_regs", {bus.h_delta, bus.v_delta, bus.piece_type, bus.resp_code,
                            bus.resp_legal}, 14'd0);
    violations = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.resp_valid || bus.chk_start != 6'd0) violations++;
    end
    check("wait_rst_no_resp", violations, 0);

    // Reset on the dispatch cycle suppresses the start strobe
    launch(3'd0, 3'd0, 3'd0, 3'd3, 1'b0);
    @(negedge clk);
    check("disp_start", bus.chk_start, 6'b001000);
    reset = 1'b1;
    #1;
    check("disp_rst_suppress", {bus.chk_start, bus.req_ready}, 7'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("disp_rst_ready", {bus.req_ready, bus.resp_valid}, 2'b10);

    // Randomized moves against the reference model
    for (int t = 0; t < 120; t++) begin
      random_board();
      ox = 3'($urandom); oy = 3'($urandom); nx = 3'($urandom); ny = 3'($urandom);
      side = 1'($urandom);
      if ($urandom_range(0, 9) < 7)
        bus.board_in[ox][oy] = {side, 3'($urandom_range(1, 6))};
      model(bus.board_in, ox, oy, nx, ny, side, $urandom_range(0, 20) == 0 ? 99 : 0,
            1'b0, rc, rl, rlat, rs);
      begin
        int dd; logic res; int stall;
        dd = $urandom_range(0, 20);
        res = 1'($urandom);
        stall = $urandom_range(0, 3);
        model(bus.board_in, ox, oy, nx, ny, side, dd, res, rc, rl, rlat, rs);
        run_txn($sformatf("rnd%0d", t), ox, oy, nx, ny, side, dd, res, stall,
                rc, rl, rlat, rs);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/move_check_sequencer.md
# move_check_sequencer

Front-end controller for the board validator's per-piece move checkers. It accepts one move request at a time and latches the move coordinates. It runs the piece-independent pre-checks itself, then starts exactly one checker selected by the moving piece's type. It waits for that checker's done/result handshake, with a watchdog, and returns one verdict with a reason code to the game-play FSM.

## Interface
Parameters:
- TIMEOUT, default 16: maximum WAIT cycles allowed for a checker's done; range 2..255.

Ports:
- clk  in  1: system clock; every register updates on its rising edge.
- reset  in  1: synchronous, active-high reset.
- req_valid  in  1: a move request is present.
- req_ready  out  1: the block can accept a request; high only in IDLE and forced low while reset is high.
- old_x, old_y, new_x, new_y  in  3 each: source and destination squares; sampled only on the accept cycle.
- side_to_move  in  1: 0 = white, 1 = black; sampled on the accept cycle.
- board_in  in  4 × [8][8]: live board, indexed [x][y]. Piece code bit3 = colour (1 = black). Bits[2:0]: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 reserved.
- h_delta, v_delta  out  3 each: registered |new_x−old_x| and |new_y−old_y|; stable from PRECHECK until the next accept.
- piece_type  out  4: registered source-square code; same stability window.
- chk_start  out  6: one-hot start strobe, bit k−1 for piece type k; one-cycle pulse.
- chk_done  in  6: per-checker completion strobe.
- chk_result  in  6: per-checker legality, sampled with the matching chk_done bit.
- resp_valid  out  1: a verdict is available.
- resp_ready  in  1: the consumer takes the verdict.
- resp_legal  out  1: 1 = move legal.
- resp_code  out  3: 0 OK, 1 empty source, 2 wrong colour, 3 null move, 4 own-piece capture, 5 illegal pattern, 6 checker timeout, 7 reserved piece code.

## Operation
- States are IDLE, PRECHECK, DISPATCH, WAIT, RESPOND.
- **IDLE:** req_ready = 1. When req_valid && req_ready, the block latches the coordinates and side_to_move, then goes to PRECHECK.
- **PRECHECK:** the block reads src = board_in[old_x][old_y] and dst = board_in[new_x][new_y], registers piece_type and both deltas, and evaluates faults in this priority order:
  - src[2:0] = 0 → code 1.
  - src[2:0] = 7 → code 7.
  - src[3] ≠ side_to_move → code 2.
  - both deltas 0 → code 3.
  - dst non-empty and dst[3] = src[3] → code 4.
  - Any fault goes to RESPOND with resp_legal = 0; no fault goes to DISPATCH.
- **DISPATCH:** the block asserts chk_start[src[2:0]−1] for this single cycle, clears the watchdog, then goes to WAIT.
- **WAIT:** the block monitors only the selected bit, sel.
  - chk_done[sel] = 1: resp_legal = chk_result[sel], code 0 if legal else 5, go to RESPOND.
  - Otherwise the watchdog increments. When it reaches TIMEOUT−1 without done: code 6, resp_legal = 0, go to RESPOND.
  - Done on the same cycle as the timeout boundary: done wins.
  - chk_done on unselected bits is ignored in every state.
- **RESPOND:** resp_valid = 1, with resp_legal and resp_code held stable. When resp_valid && resp_ready, go to IDLE.
- Board changes after PRECHECK have no effect on the current verdict.

## Timing
- Reset, sampled at a clock edge, forces state to IDLE and all outputs to 0: resp_valid, resp_legal, resp_code, chk_start, h_delta, v_delta, piece_type, and the watchdog. req_ready is 0 while reset is high and 1 on the first cycle after it deasserts.
- Reset mid-operation, in any state, aborts without emitting a response. A pending chk_start pulse is suppressed.
- Latency, with accept on cycle T:
  - A pre-check fault gives resp_valid at T+2.
  - A checker returning done on its first WAIT cycle (T+3) gives resp_valid at T+4.
  - A timeout gives resp_valid at T+3+TIMEOUT.
- Exactly one chk_start bit pulses per dispatched request, and never more than one pulse per request.
- req_ready is 0 from the cycle after accept until the cycle after the response handshake. Back-to-back throughput is therefore one request per 3 cycles for fault paths and 5 cycles for the fastest dispatched path.
- resp_ready held low stalls indefinitely in RESPOND, with the outputs stable.

## Test plan
- Reset held 3 cycles during WAIT → no resp_valid; chk_start = 0; req_ready = 1 on the first cycle after reset.
- White knight on (1,0), move to (2,2), side_to_move = 0, checker done at first WAIT cycle with result 1 → chk_start = 6'b000010 at T+2; h_delta = 1, v_delta = 2; resp_valid at T+4, legal = 1, code 0.
- Empty source square → resp_valid at T+2, code 1, no chk_start. Black rook moved while side_to_move = 0 → code 2. old = new → code 3. White bishop onto a white pawn → code 4.
- Selected checker never raises done, TIMEOUT = 16; chk_done[0] pulsed meanwhile → the stray bit is ignored; resp_valid at T+19, code 6.
- Queen checker returns result 0 while resp_ready is held low 5 cycles → verdict held stable (legal 0, code 5) until the handshake; req_ready is 1 the cycle after it.
- Done and the watchdog limit on the same cycle → code 0 or 5 from chk_result, never 6.
